// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin arbiter and access sequencer between two requesters (0: GB audio,
// 1: NES) and the DDR controller's SRAM-style port. One access is in flight at
// a time. The block drives the active-low strobes for the required number of
// cycles, synchronises the controller's data_valid, returns read data, and
// aborts a read whose data_valid never arrives.
`timescale 1ns/1ps

module ram_port_arbiter #(
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 64,
    parameter int WR_CYCLES      = 16,
    parameter int RD_TIMEOUT     = 1024,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  cpu_resetn,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]     ram_a,
    output logic [DATA_W-1:0]     ram_dq_i,
    input  logic [DATA_W-1:0]     ram_dq_o,
    output logic                  ram_cen_n,
    output logic                  ram_oen_n,
    output logic                  ram_wen_n,
    input  logic                  ram_data_valid,
    output logic                  busy,
    output logic                  err_timeout
);

    // One counter serves every timed state, so it is sized for the longest one.
    localparam int CNT_MAX_WR_RD = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
    localparam int CNT_MAX       = (CNT_MAX_WR_RD > RECOVER_CYCLES) ? CNT_MAX_WR_RD : RECOVER_CYCLES;
    localparam int CNT_W         = $clog2(CNT_MAX + 1);

    // Terminal counts. The write hold is WR_CYCLES including the ISSUE cycle,
    // so WR_HOLD itself lasts WR_CYCLES-1 cycles (counter 0 .. WR_CYCLES-2).
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'((WR_CYCLES >= 2) ? (WR_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WR_HOLD = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                last_grant_r;
    logic                gnt_r;
    logic                we_r;
    logic                dv_d1_r;
    logic                dv_d2_r;
    logic                dv_rise_s;
    logic                grant_s;
    logic [ADDR_W-1:0]   addr_sel_s;
    logic [DATA_W-1:0]   wdata_sel_s;
    logic                we_sel_s;
    logic [1:0]          gnt_onehot_s;

    // Arbitration, handshake, payload selection and status decode.
    always_comb begin
        grant_s      = 1'b0;
        req_ready    = 2'b00;
        addr_sel_s   = {ADDR_W{1'b0}};
        wdata_sel_s  = {DATA_W{1'b0}};
        we_sel_s     = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
        if (state_r == ST_IDLE) begin
            req_ready = req_valid & (grant_s ? 2'b10 : 2'b01);
        end else begin
            req_ready = 2'b00;
        end
        if (grant_s) begin
            addr_sel_s  = req_addr[2*ADDR_W-1:ADDR_W];
            wdata_sel_s = req_wdata[2*DATA_W-1:DATA_W];
            we_sel_s    = req_we[1];
        end else begin
            addr_sel_s  = req_addr[ADDR_W-1:0];
            wdata_sel_s = req_wdata[DATA_W-1:0];
            we_sel_s    = req_we[0];
        end
        busy         = (state_r != ST_IDLE);
        gnt_onehot_s = gnt_r ? 2'b10 : 2'b01;
        dv_rise_s    = dv_d1_r & ~dv_d2_r;
        cnt_inc_s    = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_W'(1));
    end

    // Two-flop synchroniser for the controller's data_valid (200 MHz domain).
    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            dv_d1_r <= 1'b0;
            dv_d2_r <= 1'b0;
        end else begin
            dv_d1_r <= ram_data_valid;
            dv_d2_r <= dv_d1_r;
        end
    end

    // Access sequencer: state, counter, strobes, latched request and response.
    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
            gnt_r        <= 1'b0;
            we_r         <= 1'b0;
            ram_a        <= {ADDR_W{1'b0}};
            ram_dq_i     <= {DATA_W{1'b0}};
            ram_cen_n    <= 1'b1;
            ram_oen_n    <= 1'b1;
            ram_wen_n    <= 1'b1;
            rsp_valid    <= 2'b00;
            rsp_rdata    <= {DATA_W{1'b0}};
            err_timeout  <= 1'b0;
        end else begin
            rsp_valid   <= 2'b00;
            err_timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|req_ready) begin
                        ram_a        <= addr_sel_s;
                        ram_dq_i     <= wdata_sel_s;
                        we_r         <= we_sel_s;
                        gnt_r        <= grant_s;
                        last_grant_r <= grant_s;
                        ram_cen_n    <= 1'b0;
                        ram_wen_n    <= ~we_sel_s;
                        ram_oen_n    <= we_sel_s;
                        cnt_r        <= {CNT_W{1'b0}};
                        state_r      <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (we_r) begin
                        if (WR_CYCLES <= 1) begin
                            ram_cen_n <= 1'b1;
                            ram_oen_n <= 1'b1;
                            ram_wen_n <= 1'b1;
                            state_r   <= ST_RECOVER;
                        end else begin
                            state_r <= ST_WR_HOLD;
                        end
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_WR_HOLD: begin
                    if (cnt_r == WR_LAST) begin
                        ram_cen_n <= 1'b1;
                        ram_oen_n <= 1'b1;
                        ram_wen_n <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ST_RECOVER;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RD_WAIT: begin
                    // Data takes priority over a coincident timeout.
                    if (dv_rise_s) begin
                        rsp_rdata <= ram_dq_o;
                        rsp_valid <= gnt_onehot_s;
                        ram_cen_n <= 1'b1;
                        ram_oen_n <= 1'b1;
                        ram_wen_n <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ST_RECOVER;
                    end else if (cnt_r == RD_LAST) begin
                        rsp_rdata   <= {DATA_W{1'b0}};
                        rsp_valid   <= gnt_onehot_s;
                        err_timeout <= 1'b1;
                        ram_cen_n   <= 1'b1;
                        ram_oen_n   <= 1'b1;
                        ram_wen_n   <= 1'b1;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_RECOVER;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_r == RC_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    ram_cen_n <= 1'b1;
                    ram_oen_n <= 1'b1;
                    ram_wen_n <= 1'b1;
                    cnt_r     <= {CNT_W{1'b0}};
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
